// File: rtl/fuzz_sched_pkg.sv
// Purpose: shared types and defaults for the fuzzification scheduler and its arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fuzz_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_IN_W    = 10;
    localparam int DEF_OUT_W   = 7;
    localparam int DEF_ENG_LAT = 3;

    // Width of an index into n items; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin arbiter, first requester at or above ptr wins (wrapping).
// Latency: purely combinational, zero cycles.
// Backpressure: none; grant follows req/ptr in the same cycle.
// Ports: req (per-channel request), ptr (search start), grant (one-hot),
//        grant_idx (index of grant), grant_any (some channel requested).
module rr_arbiter
    import fuzz_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    localparam int IDW   = id_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDW-1:0]    ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDW-1:0]    grant_idx,
    output logic              grant_any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = IDW'((int'(ptr) + i) % NUM_CH);
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fuzzification_scheduler.sv
// Purpose: time-shares one bit-serial fuzzification engine among NUM_CH requesters.
// Latency: accept at T0, result valid at T(IN_W+ENG_LAT+1); one transaction in flight.
// Backpressure: DONE holds result until res_ready; no new request accepted meanwhile.
// Ports: req_valid/req_data/req_ready  - per-channel crisp-value requests (one-hot accept)
//        eng_start/eng_bit/eng_result - serial engine interface, MSB first
//        res_valid/res_ready/res_id/res_data - tagged result output; busy = not IDLE
module fuzzification_scheduler
    import fuzz_sched_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int ENG_LAT = DEF_ENG_LAT,
    localparam int IDW    = id_w(NUM_CH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CH-1:0]      req_valid,
    input  logic [NUM_CH*IN_W-1:0] req_data,
    output logic [NUM_CH-1:0]      req_ready,
    output logic                   eng_start,
    output logic                   eng_bit,
    input  logic [OUT_W-1:0]       eng_result,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [IDW-1:0]         res_id,
    output logic [OUT_W-1:0]       res_data,
    output logic                   busy
);

    localparam int CNT_W  = id_w(IN_W);
    localparam int WCNT_W = id_w(ENG_LAT);

    state_t            state;
    state_t            state_nxt;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    ch_id;
    logic [IN_W-1:0]   shreg;
    logic [CNT_W-1:0]  cnt;
    logic [WCNT_W-1:0] wcnt;

    logic [NUM_CH-1:0] grant;
    logic [IDW-1:0]    grant_idx;
    logic              grant_any;

    // Word view of the flat request bus so the granted value is a plain index.
    logic [IN_W-1:0]   req_word [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign req_word[g] = req_data[g*IN_W +: IN_W];
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        eng_start = 1'b0;
        eng_bit   = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = grant;
                if (grant_any) state_nxt = SHIFT;
            end
            SHIFT: begin
                eng_start = 1'b1;
                eng_bit   = shreg[IN_W-1];
                if (cnt == '0) state_nxt = WAIT;
            end
            WAIT: begin
                eng_start = 1'b1;
                if (wcnt == '0) state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            ch_id    <= '0;
            shreg    <= '0;
            cnt      <= '0;
            wcnt     <= '0;
            res_id   <= '0;
            res_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        shreg <= req_word[grant_idx];
                        ch_id <= grant_idx;
                        cnt   <= CNT_W'(IN_W - 1);
                    end
                end
                SHIFT: begin
                    shreg <= {shreg[IN_W-2:0], 1'b0};
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) wcnt <= WCNT_W'(ENG_LAT - 1);
                end
                WAIT: begin
                    wcnt <= wcnt - 1'b1;
                    // Engine output is only trusted on the last wait cycle.
                    if (wcnt == '0) begin
                        res_data <= eng_result;
                        res_id   <= ch_id;
                    end
                end
                DONE: begin
                    // Served channel drops to lowest priority for the next round.
                    if (res_ready)
                        rr_ptr <= (ch_id == IDW'(NUM_CH - 1)) ? '0 : ch_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzification_scheduler.sv
module tb_fuzzification_scheduler;

    localparam int NUM_CH  = 4;
    localparam int IN_W    = 10;
    localparam int OUT_W   = 7;
    localparam int ENG_LAT = 3;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_CH-1:0]      req_valid = '0;
    logic [IN_W-1:0]        word [NUM_CH];
    logic [NUM_CH*IN_W-1:0] req_data;
    logic [NUM_CH-1:0]      req_ready;
    logic                   eng_start;
    logic                   eng_bit;
    logic [OUT_W-1:0]       eng_result;
    logic                   res_valid;
    logic                   res_ready = 1'b1;
    logic [1:0]             res_id;
    logic [OUT_W-1:0]       res_data;
    logic                   busy;

    assign req_data = {word[3], word[2], word[1], word[0]};

    always #5 clock = ~clock;

    fuzzification_scheduler #(
        .NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .ENG_LAT(ENG_LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .eng_start  (eng_start),
        .eng_bit    (eng_bit),
        .eng_result (eng_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_data   (res_data),
        .busy       (busy)
    );

    // Engine model: membership = top 7 bits OR'd with the LSB of the received word.
    function automatic logic [OUT_W-1:0] fuzz(input logic [IN_W-1:0] x);
        return x[9:3] | {6'b0, x[0]};
    endfunction

    logic [IN_W-1:0] eng_sh = '0;
    int              eng_n  = 0;

    always @(posedge clock) begin
        if (!eng_start) begin
            eng_sh <= '0;
            eng_n  <= 0;
        end else if (eng_n < IN_W) begin
            eng_sh <= {eng_sh[IN_W-2:0], eng_bit};
            eng_n  <= eng_n + 1;
        end
    end

    // Result only driven while the engine is enabled, so a late capture shows up.
    assign eng_result = eng_start ? fuzz(eng_sh) : '0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int id;
        int res;
    } exp_t;

    exp_t sb_q[$];
    int   acc_id[$];
    int   acc_cyc[$];
    int   cyc = 0;
    exp_t mon_e;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: push on request handshake, pop on result handshake.
    always @(negedge clock) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if ((req_valid & req_ready) != '0) begin
                check("ready_onehot", $countones(req_ready), 1);
                mon_e.id  = 0;
                mon_e.res = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (req_ready[i]) begin
                        mon_e.id  = i;
                        mon_e.res = int'(fuzz(word[i]));
                    end
                end
                sb_q.push_back(mon_e);
                acc_id.push_back(mon_e.id);
                acc_cyc.push_back(cyc);
            end
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_res_id", int'(res_id), mon_e.id);
                    check("sb_res_data", int'(res_data), mon_e.res);
                end
            end
        end
    end

    typedef struct {
        int                ch;
        logic [IN_W-1:0]   data;
        logic [OUT_W-1:0]  exp_res;
        logic [NUM_CH-1:0] exp_ready;
    } vec_t;

    vec_t vecs [5];
    int   rr_exp [5];

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clock);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, int'(busy), 0);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int bits, start_bad, lat, n, bad;
    logic [1:0]       hold_id;
    logic [OUT_W-1:0] hold_data;

    initial begin
        for (int i = 0; i < NUM_CH; i++) word[i] = '0;
        vecs[0] = '{2, 10'h2A5, 7'h55, 4'b0100};
        vecs[1] = '{0, 10'h3FF, 7'h7F, 4'b0001};
        vecs[2] = '{1, 10'h155, 7'h2B, 4'b0010};
        vecs[3] = '{0, 10'h0C3, 7'h19, 4'b0001};
        vecs[4] = '{3, 10'h000, 7'h00, 4'b1000};
        rr_exp  = '{0, 1, 2, 3, 0};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_eng_start", int'(eng_start), 0);
        check("rst_eng_bit", int'(eng_bit), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_res_id", int'(res_id), 0);
        check("rst_res_data", int'(res_data), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Table-driven single requests
        for (int v = 0; v < 5; v++) begin
            word[vecs[v].ch] = vecs[v].data;
            req_valid = NUM_CH'(1) << vecs[v].ch;
            @(negedge clock);
            check("v_req_ready", int'(req_ready), int'(vecs[v].exp_ready));
            @(posedge clock); #1;
            req_valid = '0;
            bits = 0;
            start_bad = 0;
            for (int k = 0; k < IN_W; k++) begin
                @(negedge clock);
                bits = (bits << 1) | int'(eng_bit);
                if (eng_start !== 1'b1) start_bad++;
                @(posedge clock); #1;
            end
            check("v_serial_bits", bits, int'(vecs[v].data));
            check("v_eng_start_high", start_bad, 0);
            lat = IN_W + 1;
            @(negedge clock);
            while (res_valid !== 1'b1 && lat < 40) begin
                @(posedge clock); #1;
                lat++;
                @(negedge clock);
            end
            check("v_latency", lat, IN_W + ENG_LAT + 1);
            check("v_res_id", int'(res_id), vecs[v].ch);
            check("v_res_data", int'(res_data), int'(vecs[v].exp_res));
            @(posedge clock); #1;
            @(negedge clock);
            check("v_idle_busy", int'(busy), 0);
            check("v_idle_eng", int'({eng_start, eng_bit}), 0);
            @(posedge clock); #1;
        end

        // Round-robin with all channels valid
        acc_id.delete();
        acc_cyc.delete();
        word[0] = 10'h101;
        word[1] = 10'h202;
        word[2] = 10'h304;
        word[3] = 10'h0F8;
        req_valid = 4'hF;
        n = 0;
        while (acc_id.size() < 5 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        req_valid = '0;
        check("rr_count", acc_id.size(), 5);
        for (int i = 0; i < acc_id.size() && i < 5; i++)
            check("rr_order", acc_id[i], rr_exp[i]);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("rr_gap", acc_cyc[i] - acc_cyc[i-1], IN_W + ENG_LAT + 2);
        wait_idle("rr_idle");

        // Backpressure in DONE
        res_ready = 1'b0;
        word[2] = 10'h0F0;
        req_valid = 4'b0100;
        n = 0;
        @(negedge clock);
        while (res_valid !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("bp_reach_done", int'(res_valid), 1);
        hold_id   = res_id;
        hold_data = res_data;
        check("bp_res_id", int'(hold_id), 2);
        check("bp_res_data", int'(hold_data), 7'h1E);
        @(posedge clock); #1;
        word[0] = 10'h3C3;
        req_valid = 4'b0001;
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (res_valid !== 1'b1 || res_id !== hold_id || res_data !== hold_data || req_ready !== '0)
                bad++;
        end
        check("bp_hold_stable", bad, 0);
        @(posedge clock); #1;
        res_ready = 1'b1;
        n = 0;
        @(negedge clock);
        while ((req_valid & req_ready) == '0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("bp_regrant_within_2", int'(n <= 2), 1);
        check("bp_regrant_ch", int'(req_ready), 4'b0001);
        @(posedge clock); #1;
        req_valid = '0;
        wait_idle("bp_idle");

        // Pointer fairness: ch0 was just served, ch3 must win next
        acc_id.delete();
        word[3] = 10'h1A7;
        word[0] = 10'h055;
        req_valid = 4'b1001;
        n = 0;
        while (acc_id.size() < 2 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        req_valid = '0;
        check("fair_count", acc_id.size(), 2);
        if (acc_id.size() >= 2) begin
            check("fair_first", acc_id[0], 3);
            check("fair_second", acc_id[1], 0);
        end
        wait_idle("fair_idle");

        // Serve ch1 so the pointer sits at 2, then abort a ch3 transaction with reset
        acc_id.delete();
        word[1] = 10'h111;
        req_valid = 4'b0010;
        n = 0;
        while (acc_id.size() < 1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        req_valid = '0;
        wait_idle("pre_rst_idle");

        word[3] = 10'h2F0;
        req_valid = 4'b1000;
        @(negedge clock);
        check("rst_mid_grant", int'(req_ready), 4'b1000);
        @(posedge clock); #1;
        req_valid = '0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_eng_start", int'(eng_start), 0);
        bad = 0;
        repeat (25) begin
            @(negedge clock);
            if (res_valid !== 1'b0) bad++;
        end
        check("rst_mid_no_result", bad, 0);
        @(posedge clock); #1;
        word[1] = 10'h0AA;
        word[3] = 10'h3F0;
        req_valid = 4'b1010;
        @(negedge clock);
        check("rst_ptr_cleared", int'(req_ready), 4'b0010);
        @(posedge clock); #1;
        req_valid = '0;
        wait_idle("rst_final_idle");

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
